// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Define MULDIV_FAST_MUL_EN to route the four multiplies through a single-cycle multiplier.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned W2 = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic [XLEN-1:0]    result_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic [W2-1:0]      acc_q;
    logic [XLEN:0]      rem_q;
    logic [XLEN-1:0]    mag_a_q;
    logic [XLEN-1:0]    mag_b_q;
    logic               neg_q;
    logic               rem_neg_q;
    logic               special_q;

    // Request decode: operand signedness, magnitudes and the RISC-V special cases.
    logic               is_div;
    logic               a_signed;
    logic               b_signed;
    logic               a_neg;
    logic               b_neg;
    logic [XLEN-1:0]    a_mag;
    logic [XLEN-1:0]    b_mag;
    logic               div_zero;
    logic               div_ovf;
    logic               special;
    logic [XLEN-1:0]    special_res;

    always_comb begin
        is_div      = funct3[2];
        a_signed    = is_div ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
        b_signed    = is_div ? ~funct3[0] : (funct3 == 3'b001);
        a_neg       = a_signed & src1[XLEN-1];
        b_neg       = b_signed & src2[XLEN-1];
        a_mag       = a_neg ? ('0 - src1) : src1;
        b_mag       = b_neg ? ('0 - src2) : src2;
        div_zero    = is_div && (src2 == '0);
        div_ovf     = is_div && !funct3[0] && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
        special     = div_zero | div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? src1 : '1;
        end else if (div_ovf) begin
            special_res = funct3[1] ? '0 : src1;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [W2-1:0] fast_a;
    logic signed [W2-1:0] fast_b;
    logic        [W2-1:0] fast_prod;

    always_comb begin
        fast_a    = {{XLEN{a_signed & src1[XLEN-1]}}, src1};
        fast_b    = {{XLEN{b_signed & src2[XLEN-1]}}, src2};
        fast_prod = fast_a * fast_b;
    end
`endif

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    logic [XLEN:0]      mul_sum;
    logic [W2-1:0]      mul_next;
    logic [XLEN+1:0]    rem_sh;
    logic [XLEN+1:0]    rem_diff;
    logic               rem_ge;
    logic [XLEN:0]      rem_next;
    logic [XLEN-1:0]    quo_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = {rem_q, acc_q[XLEN-1]};
        rem_diff = rem_sh - {2'b00, mag_b_q};
        rem_ge   = ~rem_diff[XLEN+1];
        rem_next = rem_ge ? rem_diff[XLEN:0] : rem_sh[XLEN:0];
        quo_next = {acc_q[XLEN-2:0], rem_ge};
    end

    // Sign fix-up and result selection, registered on the way into DONE.
    logic [W2-1:0]      prod_fix;
    logic [XLEN-1:0]    quo_fix;
    logic [XLEN-1:0]    rem_fix;
    logic [XLEN-1:0]    fin_res;

    always_comb begin
        prod_fix = neg_q ? ('0 - acc_q) : acc_q;
        quo_fix  = neg_q ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        rem_fix  = rem_neg_q ? ('0 - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
        fin_res  = '0;
        if (special_q) begin
            fin_res = acc_q[XLEN-1:0];
        end else if (!op_q[2]) begin
            fin_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[W2-1:XLEN];
        end else begin
            fin_res = op_q[1] ? rem_fix : quo_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            special_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q    <= 1'b1;
                        op_q      <= funct3;
                        mag_a_q   <= a_mag;
                        mag_b_q   <= b_mag;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        cnt_q     <= '0;
                        rem_q     <= '0;
                        special_q <= 1'b0;
                        if (special) begin
                            acc_q     <= {{XLEN{1'b0}}, special_res};
                            special_q <= 1'b1;
                            state_q   <= S_FIN;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!is_div) begin
                            acc_q     <= fast_prod;
                            neg_q     <= 1'b0;
                            state_q   <= S_FIN;
`endif
                        end else begin
                            acc_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (op_q[2]) begin
                        acc_q <= {acc_q[W2-1:XLEN], quo_next};
                        rem_q <= rem_next;
                    end else begin
                        acc_q <= mul_next;
                    end
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    result_q <= fin_res;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
